// File: rtl/instrumented_ring_counter_mc.sv
// instrumented_ring_counter_mc
//   Multi-channel ring-oscillator edge counter. One ring at a time is
//   enabled. Its rising edges are counted over a programmable window of
//   clk cycles. The block supports single-shot, continuous and
//   channel-sweep runs.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high; clears all state
//   ring_osc_in       raw ring outputs (asynchronous to clk)
//   ring_enable       one-hot enable of the ring being measured, else 0
//   start             level; starts a run when idle
//   stop              aborts any run (wins over start)
//   channel_sel       channel used for single/continuous runs
//   integration_time  window length in clk cycles, sampled at each arm
//   continuous        re-arm automatically after each window
//   sweep             step through channels 0..CHANNELS-1
//   busy              high while arming or counting
//   result            last completed count
//   result_channel    channel of result
//   result_overflow   count saturated in that window
//   result_valid      one-cycle pulse when result updates
//   done              sticky: run finished normally
//
// Timing: ARM (1 cycle), then COUNT (integration_time cycles), then
// COMPLETE (1 cycle, result_valid high), then ARM or IDLE.
module instrumented_ring_counter_mc #(
  parameter  int CHANNELS    = 4,
  parameter  int COUNT_WIDTH = 32,
  parameter  int TIME_WIDTH  = 32,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    ring_osc_in,
  output logic [CHANNELS-1:0]    ring_enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CH_W-1:0]        channel_sel,
  input  logic [TIME_WIDTH-1:0]  integration_time,
  input  logic                   continuous,
  input  logic                   sweep,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] result,
  output logic [CH_W-1:0]        result_channel,
  output logic                   result_overflow,
  output logic                   result_valid,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_COUNT    = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  // Build the one-hot ring enable for a channel index.
  function automatic logic [CHANNELS-1:0] onehot_f(input logic [CH_W-1:0] idx);
    logic [CHANNELS-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  state_t                 state_r, state_s;
  logic [CHANNELS-1:0]    sync1_r, sync2_r, prev_r;
  logic [CHANNELS-1:0]    edge_s;
  logic [CH_W-1:0]        channel_r, channel_s;
  logic [TIME_WIDTH-1:0]  timer_r, timer_s;
  logic [COUNT_WIDTH-1:0] counter_r, counter_s;
  logic                   overflow_r, overflow_s;
  // Set at completion when another ARM follows the COMPLETE cycle.
  logic                   cont_r, cont_s;
  logic [CHANNELS-1:0]    ring_enable_r, ring_enable_s;
  logic                   busy_r, busy_s;
  logic [COUNT_WIDTH-1:0] result_r, result_s;
  logic [CH_W-1:0]        result_channel_r, result_channel_s;
  logic                   result_overflow_r, result_overflow_s;
  logic                   result_valid_r, result_valid_s;
  logic                   done_r, done_s;

  logic                   chan_ok_s;
  logic                   edge_sel_s;
  logic                   cnt_max_s;
  logic [COUNT_WIDTH-1:0] cnt_step_s;
  logic                   ovf_step_s;
  logic                   final_s;
  logic [COUNT_WIDTH-1:0] fin_count_s;
  logic                   fin_ovf_s;

  assign edge_s     = sync2_r & ~prev_r;
  assign chan_ok_s  = (int'(channel_sel) < CHANNELS);
  assign edge_sel_s = edge_s[channel_r];
  assign cnt_max_s  = (counter_r == {COUNT_WIDTH{1'b1}});
  // The counter saturates at all-ones. An edge that arrives while saturated marks overflow.
  assign cnt_step_s = (edge_sel_s && !cnt_max_s) ? counter_r + COUNT_WIDTH'(1) : counter_r;
  assign ovf_step_s = overflow_r | (edge_sel_s & cnt_max_s);

  // Two-flop synchroniser and edge history. These run free in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= ring_osc_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Next-state and datapath decisions for the measurement FSM.
  always_comb begin
    state_s           = state_r;
    channel_s         = channel_r;
    timer_s           = timer_r;
    counter_s         = counter_r;
    overflow_s        = overflow_r;
    cont_s            = cont_r;
    result_s          = result_r;
    result_channel_s  = result_channel_r;
    result_overflow_s = result_overflow_r;
    result_valid_s    = 1'b0;
    done_s            = done_r;
    final_s           = 1'b0;
    fin_count_s       = '0;
    fin_ovf_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start && (sweep || chan_ok_s)) begin
          state_s   = ST_ARM;
          channel_s = sweep ? '0 : channel_sel;
          done_s    = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        timer_s    = integration_time;
        counter_s  = '0;
        overflow_s = 1'b0;
        if (integration_time == '0) begin
          // An empty window completes at once with a zero count.
          final_s = 1'b1;
        end else begin
          state_s = ST_COUNT;
        end
      end
      ST_COUNT: begin
        timer_s    = timer_r - TIME_WIDTH'(1);
        counter_s  = cnt_step_s;
        overflow_s = ovf_step_s;
        if (timer_r == TIME_WIDTH'(1)) begin
          final_s     = 1'b1;
          fin_count_s = cnt_step_s;
          fin_ovf_s   = ovf_step_s;
        end else begin
          state_s = ST_COUNT;
        end
      end
      ST_COMPLETE: begin
        state_s = cont_r ? ST_ARM : ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (final_s) begin
      state_s           = ST_COMPLETE;
      result_s          = fin_count_s;
      result_channel_s  = channel_r;
      result_overflow_s = fin_ovf_s;
      result_valid_s    = 1'b1;
      // The continuous and sweep inputs are sampled here, once per window.
      if (sweep) begin
        if (int'(channel_r) >= CHANNELS - 1) begin
          channel_s = '0;
          cont_s    = continuous;
          done_s    = ~continuous;
        end else begin
          channel_s = channel_r + CH_W'(1);
          cont_s    = 1'b1;
        end
      end else if (continuous) begin
        cont_s = 1'b1;
      end else begin
        cont_s = 1'b0;
        done_s = 1'b1;
      end
    end else begin
      result_valid_s = 1'b0;
    end

    // An abort drops any result produced in the same cycle.
    if (stop) begin
      state_s           = ST_IDLE;
      channel_s         = channel_r;
      cont_s            = 1'b0;
      result_s          = result_r;
      result_channel_s  = result_channel_r;
      result_overflow_s = result_overflow_r;
      result_valid_s    = 1'b0;
      done_s            = 1'b0;
    end else begin
      cont_s = cont_s;
    end
  end

  // Derive the registered ring enable and busy from the upcoming state.
  // The enable also stays on through a COMPLETE cycle that re-arms.
  always_comb begin
    ring_enable_s = '0;
    busy_s        = (state_s == ST_ARM) || (state_s == ST_COUNT);
    if (busy_s || ((state_s == ST_COMPLETE) && cont_s)) begin
      ring_enable_s = onehot_f(channel_s);
    end else begin
      ring_enable_s = '0;
    end
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      channel_r         <= '0;
      timer_r           <= '0;
      counter_r         <= '0;
      overflow_r        <= 1'b0;
      cont_r            <= 1'b0;
      ring_enable_r     <= '0;
      busy_r            <= 1'b0;
      result_r          <= '0;
      result_channel_r  <= '0;
      result_overflow_r <= 1'b0;
      result_valid_r    <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      state_r           <= state_s;
      channel_r         <= channel_s;
      timer_r           <= timer_s;
      counter_r         <= counter_s;
      overflow_r        <= overflow_s;
      cont_r            <= cont_s;
      ring_enable_r     <= ring_enable_s;
      busy_r            <= busy_s;
      result_r          <= result_s;
      result_channel_r  <= result_channel_s;
      result_overflow_r <= result_overflow_s;
      result_valid_r    <= result_valid_s;
      done_r            <= done_s;
    end
  end

  assign ring_enable     = ring_enable_r;
  assign busy            = busy_r;
  assign result          = result_r;
  assign result_channel  = result_channel_r;
  assign result_overflow = result_overflow_r;
  assign result_valid    = result_valid_r;
  assign done            = done_r;

endmodule

// File: tb/tb_instrumented_ring_counter_mc.sv
// Self-checking bench for instrumented_ring_counter_mc.
// The bench runs five rings with periods set per test. It drives a
// mix of directed and random runs. Each result_valid pulse is checked
// against counts derived from the ring periods and the window length.
module tb_instrumented_ring_counter_mc;

  localparam int CH  = 5;
  localparam int CW  = 6;
  localparam int TW  = 16;
  localparam int CHW = 3;
  localparam longint CMAX = 63;

  logic           clk;
  logic           reset;
  logic [CH-1:0]  ring_osc_in;
  logic [CH-1:0]  ring_enable;
  logic           start;
  logic           stop;
  logic [CHW-1:0] channel_sel;
  logic [TW-1:0]  integration_time;
  logic           continuous;
  logic           sweep;
  logic           busy;
  logic [CW-1:0]  result;
  logic [CHW-1:0] result_channel;
  logic           result_overflow;
  logic           result_valid;
  logic           done;

  instrumented_ring_counter_mc #(
    .CHANNELS(CH), .COUNT_WIDTH(CW), .TIME_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .ring_osc_in(ring_osc_in), .ring_enable(ring_enable),
    .start(start), .stop(stop), .channel_sel(channel_sel),
    .integration_time(integration_time), .continuous(continuous), .sweep(sweep),
    .busy(busy), .result(result), .result_channel(result_channel),
    .result_overflow(result_overflow), .result_valid(result_valid), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int per[CH];
  int ph[CH];

  // Ring model: a square wave of per[i] clk cycles, changing at the falling clk edge.
  initial begin
    ring_osc_in = '0;
    for (int i = 0; i < CH; i++) begin
      per[i] = 0;
      ph[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (per[i] > 0) begin
          ph[i] = (ph[i] + 1) % per[i];
          ring_osc_in[i] = (ph[i] < per[i] / 2);
        end else begin
          ring_osc_in[i] = 1'b0;
        end
      end
    end
  end

  longint cyc;
  longint rv_cyc[$];
  longint rv_res[$];
  longint rv_ch[$];
  longint rv_ovf[$];
  int     en_bad;

  // Monitor: logs every result pulse and watches ring_enable legality.
  initial begin
    cyc    = 0;
    en_bad = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (result_valid) begin
        rv_cyc.push_back(cyc);
        rv_res.push_back(longint'(result));
        rv_ch.push_back(longint'(result_channel));
        rv_ovf.push_back(longint'(result_overflow));
      end
      if (ring_enable != '0 && !(busy || result_valid)) en_bad++;
      if ($countones(ring_enable) > 1) en_bad++;
    end
  end

  int n_cmp;
  int n_bad;

  task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    n_cmp++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    rv_cyc.delete();
    rv_res.delete();
    rv_ch.delete();
    rv_ovf.delete();
  endtask

  task automatic pulse_start(input int ch, input int t, input logic c, input logic s, output longint arm_cyc);
    @(negedge clk);
    channel_sel      = CHW'(ch);
    integration_time = TW'(t);
    continuous       = c;
    sweep            = s;
    start            = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    arm_cyc = cyc;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int b;
    b = budget;
    while (rv_cyc.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_val("pulse_arrival", longint'(rv_cyc.size()), longint'(n), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, longint'(busy), 0, 0);
    check_val({tag, "_result"}, longint'(result), 0, 0);
    check_val({tag, "_rchan"}, longint'(result_channel), 0, 0);
    check_val({tag, "_rovf"}, longint'(result_overflow), 0, 0);
    check_val({tag, "_rvalid"}, longint'(result_valid), 0, 0);
    check_val({tag, "_done"}, longint'(done), 0, 0);
    check_val({tag, "_enable"}, longint'(ring_enable), 0, 0);
  endtask

  // Single run: one pulse after ARM + T COUNT cycles, then idle and done.
  task automatic single_run(input string tag, input int ch, input int t);
    longint s;
    longint edges;
    longint exp_cnt;
    longint exp_ovf;
    edges   = (per[ch] > 0) ? longint'(t / per[ch]) : 0;
    exp_cnt = (edges > CMAX + 1) ? CMAX : edges;
    exp_ovf = (edges > CMAX + 1) ? 1 : 0;
    clear_q();
    pulse_start(ch, t, 1'b0, 1'b0, s);
    wait_pulses(1, t + 50);
    tick(10);
    check_val({tag, "_npulse"}, longint'(rv_cyc.size()), 1, 0);
    check_val({tag, "_latency"}, rv_cyc[0] - s, longint'(t) + 1, 0);
    check_val({tag, "_count"}, rv_res[0], exp_cnt, (exp_ovf == 1) ? 0 : 1);
    check_val({tag, "_chan"}, rv_ch[0], longint'(ch), 0);
    check_val({tag, "_ovf"}, rv_ovf[0], exp_ovf, 0);
    check_val({tag, "_done"}, longint'(done), 1, 0);
    check_val({tag, "_idle"}, longint'(busy), 0, 0);
  endtask

  initial begin
    longint s;
    int n;
    n_cmp            = 0;
    n_bad            = 0;
    reset            = 1'b1;
    start            = 1'b0;
    stop             = 1'b0;
    channel_sel      = '0;
    integration_time = '0;
    continuous       = 1'b0;
    sweep            = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_all_zero("reset");

    per[0] = 4; per[1] = 8; per[2] = 16; per[3] = 32; per[4] = 12;
    tick(40);

    // Single ch2, period 8, window 80 -> 10 edges.
    per[2] = 8;
    tick(20);
    clear_q();
    pulse_start(2, 80, 1'b0, 1'b0, s);
    tick(10);
    check_val("single_enable", longint'(ring_enable), 4, 0);
    check_val("single_busy", longint'(busy), 1, 0);
    wait_pulses(1, 200);
    tick(20);
    check_val("single_npulse", longint'(rv_cyc.size()), 1, 0);
    check_val("single_latency", rv_cyc[0] - s, 81, 0);
    check_val("single_count", rv_res[0], 10, 1);
    check_val("single_chan", rv_ch[0], 2, 0);
    check_val("single_ovf", rv_ovf[0], 0, 0);
    check_val("single_done", longint'(done), 1, 0);
    check_val("single_enable_off", longint'(ring_enable), 0, 0);
    per[2] = 16;
    tick(20);

    // Saturation: 100 edges into a 6-bit counter, then a short window.
    single_run("sat", 0, 400);
    single_run("unsat", 0, 40);

    // Sweep over all channels with window 64; channel_sel must be ignored.
    clear_q();
    pulse_start(3, 64, 1'b0, 1'b1, s);
    wait_pulses(CH, 600);
    tick(10);
    sweep = 1'b0;
    check_val("sweep_npulse", longint'(rv_cyc.size()), longint'(CH), 0);
    check_val("sweep_first", rv_cyc[0] - s, 65, 0);
    for (int i = 0; i < CH; i++) begin
      check_val("sweep_chan", rv_ch[i], longint'(i), 0);
      check_val("sweep_count", rv_res[i], longint'(64 / per[i]), 1);
      if (i > 0) check_val("sweep_gap", rv_cyc[i] - rv_cyc[i-1], 66, 0);
    end
    check_val("sweep_done", longint'(done), 1, 0);
    check_val("sweep_idle", longint'(busy), 0, 0);

    // Continuous ch1 period 8 window 40: pulses every 42 cycles, then abort.
    clear_q();
    pulse_start(1, 40, 1'b1, 1'b0, s);
    wait_pulses(3, 300);
    check_val("cont_gap1", rv_cyc[1] - rv_cyc[0], 42, 0);
    check_val("cont_gap2", rv_cyc[2] - rv_cyc[1], 42, 0);
    check_val("cont_count", rv_res[1], 5, 1);
    check_val("cont_done", longint'(done), 0, 0);
    tick(20);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    continuous = 1'b0;
    check_val("stop_busy", longint'(busy), 0, 0);
    check_val("stop_enable", longint'(ring_enable), 0, 0);
    check_val("stop_done", longint'(done), 0, 0);
    n = rv_cyc.size();
    tick(100);
    check_val("stop_nopulse", longint'(rv_cyc.size()), longint'(n), 0);
    check_val("stop_hold", longint'(result), 5, 1);

    // Zero-length window.
    single_run("zero", 3, 0);

    // Out-of-range channel_sel without sweep is ignored.
    clear_q();
    pulse_start(5, 40, 1'b0, 1'b0, s);
    tick(2);
    check_val("oor_busy", longint'(busy), 0, 0);
    pulse_start(7, 40, 1'b0, 1'b0, s);
    tick(60);
    check_val("oor_nopulse", longint'(rv_cyc.size()), 0, 0);
    check_val("oor_enable", longint'(ring_enable), 0, 0);

    // A start pulse while counting must not disturb the run.
    per[2] = 8;
    tick(20);
    clear_q();
    pulse_start(2, 80, 1'b0, 1'b0, s);
    tick(20);
    channel_sel = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pulses(1, 200);
    tick(100);
    check_val("busystart_npulse", longint'(rv_cyc.size()), 1, 0);
    check_val("busystart_latency", rv_cyc[0] - s, 81, 0);
    check_val("busystart_chan", rv_ch[0], 2, 0);
    check_val("busystart_count", rv_res[0], 10, 1);

    // A reset during COUNT clears every output.
    clear_q();
    pulse_start(1, 80, 1'b0, 1'b0, s);
    tick(30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");
    tick(150);
    check_val("midreset_nopulse", longint'(rv_cyc.size()), 0, 0);

    // When start and stop arrive together, stop wins.
    clear_q();
    @(negedge clk);
    channel_sel = 3'd1;
    integration_time = TW'(20);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check_val("startstop_busy", longint'(busy), 0, 0);
    tick(60);
    check_val("startstop_nopulse", longint'(rv_cyc.size()), 0, 0);

    // Random single runs.
    for (int k = 0; k < 6; k++) begin
      int ch;
      int t;
      ch = int'($urandom_range(0, CH - 1));
      t = int'($urandom_range(20, 200));
      per[ch] = 2 * int'($urandom_range(2, 6));
      tick(30);
      single_run("rand", ch, t);
    end

    check_val("enable_legal", longint'(en_bad), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
